// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Control FSM for the multicycle RV32I-subset datapath. Each instruction is
// walked through fetch, decode, execute, memory and writeback steps. The FSM
// drives the selects of the shared 32-bit 4:1 muxes (ALU source A, ALU
// source B, result), the write enables for PC, IR, register file and data
// memory, and the ALU operation code. One instance per core.
//
// Only the state register is sequential. Every output is a combinational
// decode of the current state and the instruction fields. pc_write also
// depends on zero while in BEQ, so it is the one Mealy output.
//
// Ports
//   clk          in   1  system clock, rising-edge active
//   rst_n        in   1  asynchronous active-low reset (forces IDLE)
//   op           in   7  instruction opcode, IR[6:0]
//   funct3       in   3  IR[14:12]
//   funct7b5     in   1  IR[30]
//   zero         in   1  ALU zero flag, current cycle
//   pc_write     out  1  PC register enable
//   adr_src      out  1  memory address select: 0 = PC, 1 = result
//   mem_write    out  1  data memory write enable
//   ir_write     out  1  IR and OldPC enable
//   reg_write    out  1  register file write enable
//   result_src   out  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult
//   alu_src_a    out  2  A mux: 00 PC, 01 OldPC, 10 rs1 register
//   alu_src_b    out  2  B mux: 00 rs2 register, 01 ImmExt, 10 constant 4
//   alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//   state        out  4  current state code (debug / verification)
// ---------------------------------------------------------------------------
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [3:0] state
);

    // -----------------------------------------------------------------------
    // State codes. 11..14 are unused; they fall through to FETCH.
    // -----------------------------------------------------------------------
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_EXECI    = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;
    localparam logic [3:0] S_IDLE     = 4'd15;

    // -----------------------------------------------------------------------
    // Supported opcodes
    // -----------------------------------------------------------------------
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_ITYP = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    // -----------------------------------------------------------------------
    // ALU operation codes
    // -----------------------------------------------------------------------
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // -----------------------------------------------------------------------
    // Mux select encodings
    // -----------------------------------------------------------------------
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic [2:0] w_alu_decode;

    // -----------------------------------------------------------------------
    // State register. Reset lands in IDLE, which emits no enables, so a
    // partially executed instruction is simply abandoned.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples its inputs from before the edge.
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign state = r_state;

    // -----------------------------------------------------------------------
    // Next-state logic. The default of FETCH covers the states that end an
    // instruction, IDLE, the unused codes and unsupported opcodes in DECODE.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred for combinational outputs.
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH: begin
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYP:      w_next_state = S_EXECR;
                    OP_ITYP:      w_next_state = S_EXECI;
                    OP_JAL:       w_next_state = S_JAL;
                    OP_BEQ:       w_next_state = S_BEQ;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                w_next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_next_state = S_MEMWB;
            end
            S_EXECR, S_EXECI, S_JAL: begin
                // JAL reuses ALUWB to write the link address (PC+4 in ALUOut).
                w_next_state = S_ALUWB;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // ALU decode for EXECR / EXECI. Subtraction needs op[5] as well as
    // funct7b5: for I-type, IR[30] belongs to the immediate, so addi with a
    // large immediate must still add.
    // -----------------------------------------------------------------------
    always_comb begin
        w_alu_decode = ALU_ADD;
        case (funct3)
            3'b000:  w_alu_decode = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  w_alu_decode = ALU_SLT;
            3'b110:  w_alu_decode = ALU_OR;
            3'b111:  w_alu_decode = ALU_AND;
            default: w_alu_decode = ALU_ADD;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode. Anything not set for a state stays 0 / 00 / add.
    // -----------------------------------------------------------------------
    always_comb begin
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        alu_control = ALU_ADD;

        case (r_state)
            S_FETCH: begin
                // Read instruction at PC, and compute PC+4 straight into PC.
                adr_src     = 1'b0;
                ir_write    = 1'b1;
                alu_src_a   = SRCA_PC;
                alu_src_b   = SRCB_FOUR;
                alu_control = ALU_ADD;
                result_src  = RES_ALURES;
                pc_write    = 1'b1;
            end
            S_DECODE: begin
                // Precompute OldPC + imm so BEQ/JAL find the target in ALUOut.
                alu_src_a   = SRCA_OLDPC;
                alu_src_b   = SRCB_IMM;
                alu_control = ALU_ADD;
            end
            S_MEMADR: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_IMM;
                alu_control = ALU_ADD;
            end
            S_MEMREAD: begin
                result_src  = RES_ALUOUT;
                adr_src     = 1'b1;
            end
            S_MEMWB: begin
                result_src  = RES_DATA;
                reg_write   = 1'b1;
            end
            S_MEMWRITE: begin
                result_src  = RES_ALUOUT;
                adr_src     = 1'b1;
                mem_write   = 1'b1;
            end
            S_EXECR: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_RS2;
                alu_control = w_alu_decode;
            end
            S_EXECI: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_IMM;
                alu_control = w_alu_decode;
            end
            S_ALUWB: begin
                result_src  = RES_ALUOUT;
                reg_write   = 1'b1;
            end
            S_JAL: begin
                // PC <= branch target from ALUOut while the ALU forms OldPC+4
                // for the link register write in ALUWB.
                alu_src_a   = SRCA_OLDPC;
                alu_src_b   = SRCB_FOUR;
                alu_control = ALU_ADD;
                result_src  = RES_ALUOUT;
                pc_write    = 1'b1;
            end
            S_BEQ: begin
                // Compare rs1 - rs2; take the precomputed target when equal.
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_RS2;
                alu_control = ALU_SUB;
                result_src  = RES_ALUOUT;
                pc_write    = zero;
            end
            default: begin
                // IDLE and unused codes: everything stays at its default.
            end
        endcase
    end

endmodule
